mem_bus_arbiter: RTL and testbench

//  Shares the single 64-bit memory port between dcache_controller (loads+stores) and icache controller (loads).

---
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between both cache controllers, the arbiter and the memory port.
// The master side is the cache/memory environment; the slave side is the arbiter.
interface mem_bus_arbiter_if;
  logic [1:0]  dcache2arb_command;
  logic [63:0] dcache2arb_addr;
  logic [63:0] dcache2arb_data;
  logic [1:0]  icache2arb_command;
  logic [63:0] icache2arb_addr;
  logic [3:0]  arb2dcache_response;
  logic [3:0]  arb2icache_response;
  logic [3:0]  arb2dcache_tag;
  logic [63:0] arb2dcache_data;
  logic [3:0]  arb2icache_tag;
  logic [63:0] arb2icache_data;
  logic [1:0]  arb2mem_command;
  logic [63:0] arb2mem_addr;
  logic [63:0] arb2mem_data;
  logic [3:0]  mem2arb_response;
  logic [3:0]  mem2arb_tag;
  logic [63:0] mem2arb_data;
  logic        arb_orphan_tag;

  modport master (
    output dcache2arb_command, dcache2arb_addr, dcache2arb_data,
           icache2arb_command, icache2arb_addr,
           mem2arb_response, mem2arb_tag, mem2arb_data,
    input  arb2dcache_response, arb2icache_response,
           arb2dcache_tag, arb2dcache_data, arb2icache_tag, arb2icache_data,
           arb2mem_command, arb2mem_addr, arb2mem_data, arb_orphan_tag
  );

  modport slave (
    input  dcache2arb_command, dcache2arb_addr, dcache2arb_data,
           icache2arb_command, icache2arb_addr,
           mem2arb_response, mem2arb_tag, mem2arb_data,
    output arb2dcache_response, arb2icache_response,
           arb2dcache_tag, arb2dcache_data, arb2icache_tag, arb2icache_data,
           arb2mem_command, arb2mem_addr, arb2mem_data, arb_orphan_tag
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between dcache (loads+stores) and icache (loads).
// Grant and return steering are combinational; ownership of outstanding load
// tags is tracked so returning data reaches the requester that issued it.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input logic             clock,
  input logic             reset,
  mem_bus_arbiter_if.slave bus
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         SW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0]    CNT_MAX  = 4'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STV_MAX  = SW'(STARVE_LIMIT);

  // bit 0 is never set: tag 0 means "no tag"
  logic [15:0]   owner_valid, owner_valid_nxt;
  logic [15:0]   owner_id, owner_id_nxt;      // 0 = dcache, 1 = icache
  logic          rr_ptr, rr_ptr_nxt;          // 0 = dcache favoured
  logic [3:0]    d_cnt, d_cnt_nxt, i_cnt, i_cnt_nxt;
  logic [SW-1:0] starve_cnt, starve_cnt_nxt;

  logic d_elig, i_elig, grant_d, grant_i, accept, load_acc;
  logic ret_hit, ret_owner, d_inc, i_inc, d_dec, i_dec;
  logic [3:0] ret_tag, resp;

  assign ret_tag = bus.mem2arb_tag;
  assign resp    = bus.mem2arb_response;

  // Eligibility and grant; everything is held idle while reset is asserted
  always_comb begin
    d_elig  = reset && (bus.dcache2arb_command == BUS_STORE ||
                        (bus.dcache2arb_command == BUS_LOAD && d_cnt != CNT_MAX));
    i_elig  = reset && bus.icache2arb_command == BUS_LOAD && i_cnt != CNT_MAX;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_elig && i_elig) begin
      if (starve_cnt == STV_MAX) grant_i = 1'b1;
      else if (rr_ptr)           grant_i = 1'b1;
      else                       grant_d = 1'b1;
    end else begin
      grant_d = d_elig;
      grant_i = i_elig;
    end
    accept   = (grant_d || grant_i) && resp != 4'd0;
    load_acc = accept && (grant_i || bus.dcache2arb_command == BUS_LOAD);
    ret_hit  = reset && ret_tag != 4'd0 && owner_valid[ret_tag];
    ret_owner = owner_id[ret_tag];
  end

  // Memory-side request mux and requester-side response/return steering
  always_comb begin
    bus.arb2mem_command     = BUS_NONE;
    bus.arb2mem_addr        = '0;
    bus.arb2mem_data        = '0;
    bus.arb2dcache_response = '0;
    bus.arb2icache_response = '0;
    bus.arb2dcache_tag      = '0;
    bus.arb2dcache_data     = '0;
    bus.arb2icache_tag      = '0;
    bus.arb2icache_data     = '0;
    bus.arb_orphan_tag      = 1'b0;
    if (grant_d) begin
      bus.arb2mem_command     = bus.dcache2arb_command;
      bus.arb2mem_addr        = bus.dcache2arb_addr;
      bus.arb2mem_data        = bus.dcache2arb_data;
      bus.arb2dcache_response = resp;
    end else if (grant_i) begin
      bus.arb2mem_command     = BUS_LOAD;
      bus.arb2mem_addr        = bus.icache2arb_addr;
      bus.arb2icache_response = resp;
    end
    if (ret_hit) begin
      if (ret_owner) begin
        bus.arb2icache_tag  = ret_tag;
        bus.arb2icache_data = bus.mem2arb_data;
      end else begin
        bus.arb2dcache_tag  = ret_tag;
        bus.arb2dcache_data = bus.mem2arb_data;
      end
    end else if (reset && ret_tag != 4'd0) begin
      bus.arb_orphan_tag = 1'b1;
    end
  end

  // Next-state: return clears before accept sets, so a reused tag keeps its new owner
  always_comb begin
    owner_valid_nxt = owner_valid;
    owner_id_nxt    = owner_id;
    if (ret_hit) owner_valid_nxt[ret_tag] = 1'b0;
    if (load_acc) begin
      owner_valid_nxt[resp] = 1'b1;
      owner_id_nxt[resp]    = grant_i;
    end
    d_inc     = load_acc && grant_d;
    i_inc     = load_acc && grant_i;
    d_dec     = ret_hit && !ret_owner;
    i_dec     = ret_hit && ret_owner;
    d_cnt_nxt = d_cnt + {3'b0, d_inc} - {3'b0, d_dec};
    i_cnt_nxt = i_cnt + {3'b0, i_inc} - {3'b0, i_dec};
    rr_ptr_nxt = accept ? grant_d : rr_ptr;
    starve_cnt_nxt = starve_cnt;
    if (accept && grant_i)
      starve_cnt_nxt = '0;
    else if (grant_d && i_elig && starve_cnt != STV_MAX)
      starve_cnt_nxt = starve_cnt + 1'b1;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_valid <= '0;
      owner_id    <= '0;
      rr_ptr      <= 1'b0;
      d_cnt       <= '0;
      i_cnt       <= '0;
      starve_cnt  <= '0;
    end else begin
      owner_valid <= owner_valid_nxt;
      owner_id    <= owner_id_nxt;
      rr_ptr      <= rr_ptr_nxt;
      d_cnt       <= d_cnt_nxt;
      i_cnt       <= i_cnt_nxt;
      starve_cnt  <= starve_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios followed by random
// traffic, with expected outputs computed by a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int MAXO  = 8;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arbiter_if bus ();
  mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  dresp;
    logic [3:0]  iresp;
    logic [3:0]  dtag;
    logic [63:0] ddata;
    logic [3:0]  itag;
    logic [63:0] idata;
    logic        orphan;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t exp_q[$];

  // reference model: who owns each tag (-1 = nobody), per-requester loads in flight
  int owner [16];
  int dcnt, icnt, rr, starve;

  function automatic void model_reset();
    for (int t = 0; t < 16; t++) owner[t] = -1;
    dcnt = 0; icnt = 0; rr = 0; starve = 0;
  endfunction

  // Apply one cycle of inputs, predict this cycle's outputs and the state after the edge
  task automatic step(input logic r, input logic [1:0] dc, input logic [63:0] da,
                      input logic [63:0] dd, input logic [1:0] ic, input logic [63:0] ia,
                      input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
    obs_t e;
    int   win;
    bit   de, ie;
    exp_t x;
    rst = r;
    bus.dcache2arb_command = dc; bus.dcache2arb_addr = da; bus.dcache2arb_data = dd;
    bus.icache2arb_command = ic; bus.icache2arb_addr = ia;
    bus.mem2arb_response = mr; bus.mem2arb_tag = mt; bus.mem2arb_data = md;
    e = '0;
    if (!r) begin
      model_reset();
    end else begin
      de  = (dc == 2'd2) || (dc == 2'd1 && dcnt < MAXO);
      ie  = (ic == 2'd1) && icnt < MAXO;
      win = -1;
      if (de && ie) win = (starve == LIMIT) ? 1 : rr;
      else if (de)  win = 0;
      else if (ie)  win = 1;
      if (win == 0) begin
        e.cmd = dc; e.addr = da; e.data = dd; e.dresp = mr;
      end else if (win == 1) begin
        e.cmd = 2'd1; e.addr = ia; e.iresp = mr;
      end
      if (mt != 0) begin
        if (owner[mt] == 0)      begin e.dtag = mt; e.ddata = md; dcnt--; end
        else if (owner[mt] == 1) begin e.itag = mt; e.idata = md; icnt--; end
        else e.orphan = 1'b1;
        owner[mt] = -1;
      end
      if (win >= 0 && mr != 0) begin
        rr = 1 - win;
        if (win == 1 || dc == 2'd1) begin
          owner[mr] = win;
          if (win == 0) dcnt++; else icnt++;
        end
        if (win == 1) starve = 0;
      end
      if (win == 0 && ie && starve < LIMIT) starve++;
    end
    x.cyc = cyc;
    x.o   = e;
    if (e != '0) exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] mt, input logic [63:0] md);
    step(1'b1, 2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, mt, md);
  endtask

  // Monitor: compares every cycle; pops the scoreboard whenever an entry is due
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      a = {bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data,
           bus.arb2dcache_response, bus.arb2icache_response,
           bus.arb2dcache_tag, bus.arb2dcache_data,
           bus.arb2icache_tag, bus.arb2icache_data, bus.arb_orphan_tag};
      e = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front().o;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, a, e);
      end
    end
  end

  initial begin
    logic [1:0]  dc, ic;
    logic [3:0]  mr, mt;
    logic        r;
    int          t;
    model_reset();
    bus.dcache2arb_command = 0; bus.dcache2arb_addr = 0; bus.dcache2arb_data = 0;
    bus.icache2arb_command = 0; bus.icache2arb_addr = 0;
    bus.mem2arb_response = 0; bus.mem2arb_tag = 0; bus.mem2arb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    // reset held with traffic present: outputs must stay idle
    step(1'b0, 2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 4'd3, 4'd3, 64'h1);
    step(1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    // 1: dcache load, tag 3 returns to dcache
    step(1'b1, 2'd1, 64'h100, 64'd0, 2'd0, 64'd0, 4'd3, 4'd0, 64'd0);
    idle(4'd0, 64'd0);
    idle(4'd3, 64'hDEAD);
    // 2: both loading, accepts alternate; a rejected cycle keeps rr
    for (int k = 1; k <= 4; k++)
      step(1'b1, 2'd1, 64'h1000 + k, 64'd0, 2'd1, 64'h2000 + k, 4'(k), 4'd0, 64'd0);
    step(1'b1, 2'd1, 64'h1005, 64'd0, 2'd1, 64'h2005, 4'd0, 4'd0, 64'd0);
    step(1'b1, 2'd1, 64'h1006, 64'd0, 2'd1, 64'h2006, 4'd0, 4'd0, 64'd0);
    for (int k = 1; k <= 4; k++) idle(4'(k), 64'hA0 + k);
    // 3: dcache store hogging with rejects; icache forced after the limit
    for (int k = 0; k < 5; k++)
      step(1'b1, 2'd2, 64'h300, 64'h55, 2'd1, 64'h400, 4'd0, 4'd0, 64'd0);
    step(1'b1, 2'd2, 64'h300, 64'h55, 2'd1, 64'h400, 4'd6, 4'd0, 64'd0);
    idle(4'd6, 64'h66);
    // 4: icache fills its budget; ninth load masked until a return
    for (int k = 1; k <= 8; k++)
      step(1'b1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h500 + k, 4'(k), 4'd0, 64'd0);
    step(1'b1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h509, 4'd9, 4'd0, 64'd0);
    step(1'b1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h509, 4'd9, 4'd1, 64'hB1);
    step(1'b1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h509, 4'd9, 4'd0, 64'd0);
    for (int k = 2; k <= 9; k++) idle(4'(k), 64'hB0 + k);
    // 5: orphan return
    idle(4'd7, 64'h77);
    // 6: tag 5 returns to icache while dcache is handed tag 5
    step(1'b1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h600, 4'd5, 4'd0, 64'd0);
    step(1'b1, 2'd1, 64'h700, 64'd0, 2'd0, 64'd0, 4'd5, 4'd5, 64'hC5);
    idle(4'd5, 64'hD5);
    // 7: reset mid-traffic orphans old tags
    step(1'b1, 2'd1, 64'h800, 64'd0, 2'd1, 64'h900, 4'd2, 4'd0, 64'd0);
    step(1'b0, 2'd1, 64'h800, 64'd0, 2'd1, 64'h900, 4'd4, 4'd0, 64'd0);
    idle(4'd2, 64'hE2);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) != 0);
      dc = 2'($urandom_range(0, 2));
      ic = 2'($urandom_range(0, 2));
      mt = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      mr = 4'd0;
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 16; k++) begin
          t = $urandom_range(1, 15);
          if (owner[t] == -1 || t == int'(mt)) begin
            mr = 4'(t);
            break;
          end
        end
      end
      step(r, dc, {$urandom, $urandom}, {$urandom, $urandom}, ic,
           {$urandom, $urandom}, mr, mt, {$urandom, $urandom});
    end
    idle(4'd0, 64'd0);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
